pipelined_datapath: RTL and testbench

// - Three-stage pipelined successor of the single-cycle datapath: register read (RD), execute/memory (EX), writeback (WB).
// - Takes one decoded micro-op per cycle from the control unit (valid/ready), reuses Register_file, ALU and Mem.
// - Adds operand forwarding, a load-use stall and a no-forwarding mode; sits between control unit and memory.

---
 rtl/datapath_pkg.sv | 67 ++++++
 rtl/dp_hazard_unit.sv | 52 +++++
 rtl/pipelined_datapath.sv | 123 ++++++++++++
 tb/tb_pipelined_datapath.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the pipelined datapath: ALU opcodes, forwarding selects,
// the per-stage micro-op record and the ALU function itself.
package datapath_pkg;

   localparam int DP_WIDTH    = 16;
   localparam int DP_D_ADDR_W = 8;
   localparam int DP_R_ADDR_W = 4;

   typedef enum logic [3:0] {
      A_ZERO = 4'h0,
      ADD    = 4'h1,
      SUB    = 4'h2,
      AND_AB = 4'h3,
      OR_AB  = 4'h4,
      XOR_AB = 4'h5,
      NOT_A  = 4'h6,
      PASS_A = 4'h7,
      PASS_B = 4'h8,
      INC_A  = 4'h9,
      DEC_A  = 4'hA,
      SHL_A  = 4'hB,
      SHR_A  = 4'hC
   } alu_op_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_EX = 2'd1,
      FWD_WB = 2'd2
   } fwd_sel_t;

   // An all-zero uop_t is a bubble: invalid, A_ZERO, zero operands.
   typedef struct packed {
      logic                   valid;
      logic [DP_D_ADDR_W-1:0] d_addr;
      logic                   d_wr;
      logic                   rf_s;
      logic                   rf_w_en;
      logic [DP_R_ADDR_W-1:0] rf_w_addr;
      logic [DP_WIDTH-1:0]    a;
      logic [DP_WIDTH-1:0]    b;
      alu_op_t                alu_sel;
   } uop_t;

   // Results wrap modulo 2**DP_WIDTH; unused encodings produce zero.
   function automatic logic [DP_WIDTH-1:0] alu_eval(alu_op_t op,
                                                    logic [DP_WIDTH-1:0] a,
                                                    logic [DP_WIDTH-1:0] b);
      logic [DP_WIDTH-1:0] r;
      case (op)
         ADD:     r = a + b;
         SUB:     r = a - b;
         AND_AB:  r = a & b;
         OR_AB:   r = a | b;
         XOR_AB:  r = a ^ b;
         NOT_A:   r = ~a;
         PASS_A:  r = a;
         PASS_B:  r = b;
         INC_A:   r = a + DP_WIDTH'(1);
         DEC_A:   r = a - DP_WIDTH'(1);
         SHL_A:   r = {a[DP_WIDTH-2:0], 1'b0};
         SHR_A:   r = {1'b0, a[DP_WIDTH-1:1]};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dp_hazard_unit.sv
// Combinational RAW hazard detection for the RD stage: operand forwarding
// selects and the stall request, with or without forwarding paths.
module dp_hazard_unit
   import datapath_pkg::*;
#(
   parameter bit FORWARD = 1'b1
) (
   input  logic [DP_R_ADDR_W-1:0] rd_a_addr,
   input  logic [DP_R_ADDR_W-1:0] rd_b_addr,
   input  uop_t                   ex_uop,
   input  uop_t                   wb_uop,
   output logic                   stall,
   output fwd_sel_t               fwd_a_sel,
   output fwd_sel_t               fwd_b_sel
);

   logic ex_writes, wb_writes;
   logic ex_a_hit, ex_b_hit, wb_a_hit, wb_b_hit;
   logic unused_uop_bits;

   // Fields the hazard check has no interest in.
   assign unused_uop_bits = ^{ex_uop.d_addr, ex_uop.d_wr, ex_uop.a, ex_uop.b, ex_uop.alu_sel,
                              wb_uop.d_addr, wb_uop.d_wr, wb_uop.rf_s, wb_uop.a, wb_uop.b,
                              wb_uop.alu_sel};

   // NOTE: every output gets a default first, so no path through the
   // branches below can leave a value held and infer a latch.
   always_comb begin
      stall     = 1'b0;
      fwd_a_sel = FWD_RF;
      fwd_b_sel = FWD_RF;

      ex_writes = ex_uop.valid & ex_uop.rf_w_en;
      wb_writes = wb_uop.valid & wb_uop.rf_w_en;
      ex_a_hit  = ex_writes && (ex_uop.rf_w_addr == rd_a_addr);
      ex_b_hit  = ex_writes && (ex_uop.rf_w_addr == rd_b_addr);
      wb_a_hit  = wb_writes && (wb_uop.rf_w_addr == rd_a_addr);
      wb_b_hit  = wb_writes && (wb_uop.rf_w_addr == rd_b_addr);

      if (FORWARD) begin
         // A load's data only exists in WB, so a consumer directly behind it waits one cycle.
         stall = !ex_uop.rf_s && (ex_a_hit || ex_b_hit);
         if (ex_a_hit && ex_uop.rf_s) fwd_a_sel = FWD_EX;
         else if (wb_a_hit)           fwd_a_sel = FWD_WB;
         if (ex_b_hit && ex_uop.rf_s) fwd_b_sel = FWD_EX;
         else if (wb_b_hit)           fwd_b_sel = FWD_WB;
      end else begin
         stall = ex_a_hit || ex_b_hit || wb_a_hit || wb_b_hit;
      end
   end

endmodule

// File: rtl/pipelined_datapath.sv
// Three-stage datapath (RD / EX / WB) taking one decoded micro-op per cycle,
// with operand forwarding, load-use stall, register file and data memory.
module pipelined_datapath
   import datapath_pkg::*;
#(
   parameter int WIDTH    = DP_WIDTH,
   parameter int D_ADDR_W = DP_D_ADDR_W,
   parameter int R_ADDR_W = DP_R_ADDR_W,
   parameter bit FORWARD  = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [D_ADDR_W-1:0] D_addr,
   input  logic                D_wr,
   input  logic                RF_s,
   input  logic                RF_W_en,
   input  logic [R_ADDR_W-1:0] RF_W_addr,
   input  logic [R_ADDR_W-1:0] RF_A_addr,
   input  logic [R_ADDR_W-1:0] RF_B_addr,
   input  logic [3:0]          ALU_sel,
   output logic [WIDTH-1:0]    ALU_A,
   output logic [WIDTH-1:0]    ALU_B,
   output logic [WIDTH-1:0]    ALU_Out,
   output logic                wb_valid,
   output logic [R_ADDR_W-1:0] wb_addr,
   output logic [WIDTH-1:0]    wb_data
);

   uop_t             rd_uop, ex_q, wb_q;
   logic [WIDTH-1:0] wb_alu_q, mem_rd_q;
   logic [WIDTH-1:0] rf  [2**R_ADDR_W];
   logic [WIDTH-1:0] mem [2**D_ADDR_W];
   logic [WIDTH-1:0] rf_a, rf_b, fwd_a, fwd_b, ex_alu;
   fwd_sel_t         fwd_a_sel, fwd_b_sel;
   logic             stall, take;

   dp_hazard_unit #(.FORWARD(FORWARD)) u_hazard (
      .rd_a_addr (RF_A_addr),
      .rd_b_addr (RF_B_addr),
      .ex_uop    (ex_q),
      .wb_uop    (wb_q),
      .stall     (stall),
      .fwd_a_sel (fwd_a_sel),
      .fwd_b_sel (fwd_b_sel)
   );

   assign in_ready = !stall;
   assign take     = in_valid && in_ready;

   // ---------------- RD: register read and forwarding ----------------
   assign rf_a = rf[RF_A_addr];
   assign rf_b = rf[RF_B_addr];

   always_comb begin
      case (fwd_a_sel)
         FWD_EX:  fwd_a = ex_alu;
         FWD_WB:  fwd_a = wb_data;
         default: fwd_a = rf_a;
      endcase
      case (fwd_b_sel)
         FWD_EX:  fwd_b = ex_alu;
         FWD_WB:  fwd_b = wb_data;
         default: fwd_b = rf_b;
      endcase
   end

   always_comb begin
      rd_uop           = '0;
      rd_uop.valid     = 1'b1;
      rd_uop.d_addr    = D_addr;
      rd_uop.d_wr      = D_wr;
      rd_uop.rf_s      = RF_s;
      rd_uop.rf_w_en   = RF_W_en;
      rd_uop.rf_w_addr = RF_W_addr;
      rd_uop.a         = fwd_a;
      rd_uop.b         = fwd_b;
      rd_uop.alu_sel   = alu_op_t'(ALU_sel);
   end

   // ---------------- stage registers ----------------
   // NOTE: non-blocking assignments so EX and WB both shift on the same
   // edge from their pre-edge values, whatever order the statements are in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q     <= '0;
         wb_q     <= '0;
         wb_alu_q <= '0;
      end else begin
         ex_q     <= take ? rd_uop : '0;
         wb_q     <= ex_q;
         wb_alu_q <= ex_alu;
      end
   end

   // ---------------- EX: ALU and data memory ----------------
   assign ex_alu  = alu_eval(ex_q.alu_sel, ex_q.a, ex_q.b);
   assign ALU_A   = ex_q.a;
   assign ALU_B   = ex_q.b;
   assign ALU_Out = ex_alu;

   // NOTE: the data memory is deliberately left without reset so it maps onto
   // RAM; only the small register file is cleared. A cleared ex_q stops writes.
   always_ff @(posedge clk) begin
      if (ex_q.valid && ex_q.d_wr) mem[ex_q.d_addr] <= ex_q.a;
      mem_rd_q <= mem[ex_q.d_addr];
   end

   // ---------------- WB: source select and register write ----------------
   assign wb_valid = wb_q.valid && wb_q.rf_w_en;
   assign wb_addr  = wb_valid ? wb_q.rf_w_addr : '0;
   assign wb_data  = !wb_valid ? '0 : (wb_q.rf_s ? wb_alu_q : mem_rd_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**R_ADDR_W; i++) rf[i] <= '0;
      end else if (wb_valid) begin
         rf[wb_addr] <= wb_data;
      end
   end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench: a FORWARD=1 and a FORWARD=0 instance driven by directed
// and random micro-op streams, compared against an in-order architectural model.
module tb_pipelined_datapath;
   import datapath_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  in_valid, in_ready, D_wr, RF_s, RF_W_en, wb_valid;
   logic [7:0]  D_addr    [2];
   logic [3:0]  RF_W_addr [2];
   logic [3:0]  RF_A_addr [2];
   logic [3:0]  RF_B_addr [2];
   logic [3:0]  ALU_sel   [2];
   logic [3:0]  wb_addr   [2];
   logic [15:0] ALU_A     [2];
   logic [15:0] ALU_B     [2];
   logic [15:0] ALU_Out   [2];
   logic [15:0] wb_data   [2];

   pipelined_datapath #(.FORWARD(1'b1)) dut_fwd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .D_addr(D_addr[0]), .D_wr(D_wr[0]), .RF_s(RF_s[0]), .RF_W_en(RF_W_en[0]),
      .RF_W_addr(RF_W_addr[0]), .RF_A_addr(RF_A_addr[0]), .RF_B_addr(RF_B_addr[0]),
      .ALU_sel(ALU_sel[0]), .ALU_A(ALU_A[0]), .ALU_B(ALU_B[0]), .ALU_Out(ALU_Out[0]),
      .wb_valid(wb_valid[0]), .wb_addr(wb_addr[0]), .wb_data(wb_data[0]));

   pipelined_datapath #(.FORWARD(1'b0)) dut_nf (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .D_addr(D_addr[1]), .D_wr(D_wr[1]), .RF_s(RF_s[1]), .RF_W_en(RF_W_en[1]),
      .RF_W_addr(RF_W_addr[1]), .RF_A_addr(RF_A_addr[1]), .RF_B_addr(RF_B_addr[1]),
      .ALU_sel(ALU_sel[1]), .ALU_A(ALU_A[1]), .ALU_B(ALU_B[1]), .ALU_Out(ALU_Out[1]),
      .wb_valid(wb_valid[1]), .wb_addr(wb_addr[1]), .wb_data(wb_data[1]));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] addr;
      logic       wr, s, wen;
      logic [3:0] dst, ra, rb, sel;
   } op_t;
   typedef struct { int at_edge; logic [3:0] addr; logic [15:0] data; } wb_exp_t;
   typedef struct { int at_edge; logic wen; logic load; logic [3:0] dst; } hist_t;

   int          errors = 0;
   int          checks = 0;
   int          edge_cnt = 0;
   wb_exp_t     exp_q [2][$];
   hist_t       hist  [2][$];
   logic [15:0] m_rf  [2][16];
   logic [15:0] m_mem [2][256];
   bit          m_known [2][256];

   // Reference ALU on plain integers, wrapped to 16 bits.
   function automatic logic [15:0] ref_alu(logic [3:0] sel, logic [15:0] a, logic [15:0] b);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (alu_op_t'(sel))
         ADD:     r = ia + ib;
         SUB:     r = ia - ib + 65536;
         AND_AB:  r = int'(a & b);
         OR_AB:   r = int'(a | b);
         XOR_AB:  r = int'(a ^ b);
         NOT_A:   r = 65535 - ia;
         PASS_A:  r = ia;
         PASS_B:  r = ib;
         INC_A:   r = ia + 1;
         DEC_A:   r = ia + 65535;
         SHL_A:   r = ia * 2;
         SHR_A:   r = ia / 2;
         default: r = 0;
      endcase
      return 16'(r % 65536);
   endfunction

   function automatic op_t mk_alu(logic [3:0] sel, logic [3:0] dst, logic [3:0] ra,
                                  logic [3:0] rb, logic wen);
      op_t o;
      o.addr = 8'd0; o.wr = 1'b0; o.s = 1'b1; o.wen = wen;
      o.dst = dst; o.ra = ra; o.rb = rb; o.sel = sel;
      return o;
   endfunction

   function automatic op_t mk_load(logic [3:0] dst, logic [7:0] addr);
      op_t o;
      o.addr = addr; o.wr = 1'b0; o.s = 1'b0; o.wen = 1'b1;
      o.dst = dst; o.ra = 4'd15; o.rb = 4'd15; o.sel = A_ZERO;
      return o;
   endfunction

   function automatic op_t mk_store(logic [3:0] ra, logic [7:0] addr);
      op_t o;
      o.addr = addr; o.wr = 1'b1; o.s = 1'b1; o.wen = 1'b0;
      o.dst = 4'd0; o.ra = ra; o.rb = ra; o.sel = PASS_A;
      return o;
   endfunction

   // Advance one edge, then compare both writeback ports against the scoreboard.
   task automatic cycle();
      wb_exp_t e;
      @(posedge clk);
      #1;
      edge_cnt++;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (exp_q[k].size() > 0 && exp_q[k][0].at_edge == edge_cnt) begin
            e = exp_q[k].pop_front();
            if (wb_valid[k] !== 1'b1 || wb_addr[k] !== e.addr || wb_data[k] !== e.data) begin
               errors++;
               $display("FAIL wb%0d edge %0d: got valid=%b r%0d=%h, expected valid=1 r%0d=%h",
                        k, edge_cnt, wb_valid[k], wb_addr[k], wb_data[k], e.addr, e.data);
            end
         end else if (wb_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL wb%0d idle edge %0d: got valid=%b, expected 0", k, edge_cnt, wb_valid[k]);
         end
      end
   endtask

   // Present one op on instance k, wait for acceptance, check stall length and EX values.
   task automatic issue(int k, op_t op, output int stalls);
      int          need, exp_st;
      logic [15:0] a, b, res, data;
      exp_st = 0;
      foreach (hist[k][i]) begin
         if (hist[k][i].wen && (hist[k][i].dst == op.ra || hist[k][i].dst == op.rb)) begin
            // Producer accepted at edge P: a load is usable from WB (P+2), anything is in the RF by P+3.
            if (k == 0) need = hist[k][i].load ? hist[k][i].at_edge + 1 - edge_cnt : 0;
            else        need = hist[k][i].at_edge + 2 - edge_cnt;
            if (need > exp_st) exp_st = need;
         end
      end
      D_addr[k] = op.addr; D_wr[k] = op.wr; RF_s[k] = op.s; RF_W_en[k] = op.wen;
      RF_W_addr[k] = op.dst; RF_A_addr[k] = op.ra; RF_B_addr[k] = op.rb; ALU_sel[k] = op.sel;
      in_valid[k] = 1'b1;
      #1;
      stalls = 0;
      while (in_ready[k] !== 1'b1 && stalls < 6) begin
         cycle();
         stalls++;
      end
      checks++;
      if (stalls != exp_st) begin
         errors++;
         $display("FAIL stall inst%0d edge %0d: got %0d cycles, expected %0d", k, edge_cnt, stalls, exp_st);
      end
      cycle();
      in_valid[k] = 1'b0;
      a   = m_rf[k][op.ra];
      b   = m_rf[k][op.rb];
      res = ref_alu(op.sel, a, b);
      checks++;
      if (ALU_A[k] !== a) begin
         errors++;
         $display("FAIL alu_a inst%0d edge %0d: got %h, expected %h", k, edge_cnt, ALU_A[k], a);
      end
      checks++;
      if (ALU_B[k] !== b) begin
         errors++;
         $display("FAIL alu_b inst%0d edge %0d: got %h, expected %h", k, edge_cnt, ALU_B[k], b);
      end
      checks++;
      if (ALU_Out[k] !== res) begin
         errors++;
         $display("FAIL alu_out inst%0d edge %0d: got %h, expected %h", k, edge_cnt, ALU_Out[k], res);
      end
      if (op.wr) begin
         m_mem[k][op.addr]   = a;
         m_known[k][op.addr] = 1'b1;
      end
      if (op.wen) begin
         data = op.s ? res : m_mem[k][op.addr];
         m_rf[k][op.dst] = data;
         exp_q[k].push_back('{edge_cnt + 1, op.dst, data});
      end
      hist[k].push_back('{edge_cnt, op.wen, op.wen && !op.s, op.dst});
      while (hist[k].size() > 2) void'(hist[k].pop_front());
   endtask

   task automatic clear_model_after_reset();
      for (int k = 0; k < 2; k++) begin
         exp_q[k].delete();
         hist[k].delete();
         for (int r = 0; r < 16; r++) m_rf[k][r] = 16'h0;
      end
   endtask

   task automatic check_idle_outputs(string tag);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ALU_A[k] !== 16'h0 || ALU_B[k] !== 16'h0 || ALU_Out[k] !== 16'h0) begin
            errors++;
            $display("FAIL %s ex%0d: got A=%h B=%h Out=%h, expected all 0", tag, k, ALU_A[k], ALU_B[k], ALU_Out[k]);
         end
         checks++;
         if (wb_valid[k] !== 1'b0 || wb_addr[k] !== 4'h0 || wb_data[k] !== 16'h0) begin
            errors++;
            $display("FAIL %s wb%0d: got valid=%b addr=%h data=%h, expected 0", tag, k, wb_valid[k], wb_addr[k], wb_data[k]);
         end
      end
   endtask

   task automatic test_reset();
      cycle();
      cycle();
      check_idle_outputs("reset");
      rst_n = 1'b1;
      cycle();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset inst%0d: got %b, expected 1", k, in_ready[k]);
         end
      end
   endtask

   task automatic test_load();
      int st;
      for (int i = 0; i < 5; i++) issue(0, mk_alu(INC_A, 4'd6, 4'd6, 4'd6, 1'b1), st);
      issue(0, mk_store(4'd6, 8'd3), st);
      issue(0, mk_load(4'd1, 8'd3), st);
      cycle();
      checks++;
      if (wb_valid[0] !== 1'b1 || wb_addr[0] !== 4'd1 || wb_data[0] !== 16'h0005) begin
         errors++;
         $display("FAIL load_wb: got valid=%b r%0d=%h, expected valid=1 r1=0005", wb_valid[0], wb_addr[0], wb_data[0]);
      end
   endtask

   task automatic test_load_use();
      int st;
      issue(0, mk_load(4'd1, 8'd3), st);
      issue(0, mk_alu(ADD, 4'd2, 4'd1, 4'd1, 1'b1), st);
      checks++;
      if (st != 1) begin
         errors++;
         $display("FAIL load_use_stall: got %0d cycles, expected 1", st);
      end
      cycle();
      checks++;
      if (wb_addr[0] !== 4'd2 || wb_data[0] !== 16'h000A) begin
         errors++;
         $display("FAIL load_use_wb: got r%0d=%h, expected r2=000a", wb_addr[0], wb_data[0]);
      end
   endtask

   task automatic test_ex_forward();
      int st;
      issue(0, mk_alu(ADD, 4'd2, 4'd1, 4'd1, 1'b1), st);
      issue(0, mk_alu(ADD, 4'd3, 4'd2, 4'd1, 1'b1), st);
      checks++;
      if (st != 0 || ALU_A[0] !== 16'h000A) begin
         errors++;
         $display("FAIL ex_forward: got stall=%0d ALU_A=%h, expected stall=0 ALU_A=000a", st, ALU_A[0]);
      end
      cycle();
      checks++;
      if (wb_addr[0] !== 4'd3 || wb_data[0] !== 16'h000F) begin
         errors++;
         $display("FAIL ex_forward_wb: got r%0d=%h, expected r3=000f", wb_addr[0], wb_data[0]);
      end
   endtask

   task automatic test_store_load();
      int st;
      issue(0, mk_alu(ADD, 4'd4, 4'd3, 4'd1, 1'b1), st);
      issue(0, mk_store(4'd4, 8'd7), st);
      issue(0, mk_load(4'd5, 8'd7), st);
      cycle();
      checks++;
      if (wb_addr[0] !== 4'd5 || wb_data[0] !== 16'h0014) begin
         errors++;
         $display("FAIL store_load: got r%0d=%h, expected r5=0014", wb_addr[0], wb_data[0]);
      end
   endtask

   task automatic test_no_forward();
      int st;
      for (int i = 0; i < 5; i++) issue(1, mk_alu(INC_A, 4'd1, 4'd1, 4'd1, 1'b1), st);
      issue(1, mk_alu(ADD, 4'd2, 4'd1, 4'd1, 1'b1), st);
      issue(1, mk_alu(ADD, 4'd3, 4'd2, 4'd1, 1'b1), st);
      checks++;
      if (st != 2) begin
         errors++;
         $display("FAIL nofwd_stall: got %0d cycles, expected 2", st);
      end
      cycle();
      checks++;
      if (wb_addr[1] !== 4'd3 || wb_data[1] !== 16'h000F) begin
         errors++;
         $display("FAIL nofwd_wb: got r%0d=%h, expected r3=000f", wb_addr[1], wb_data[1]);
      end
   endtask

   task automatic test_random();
      int   st, kind;
      op_t  op;
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 7));
            op = mk_alu(4'($urandom_range(0, 12)), 4'($urandom_range(0, 3)),
                        4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                        1'($urandom_range(0, 4) != 0));
            if (kind == 6) op = mk_store(4'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            if (kind == 7 && m_known[k][op.addr[1:0]])
               op = mk_load(4'($urandom_range(0, 3)), {6'd0, op.addr[1:0]});
            issue(k, op, st);
            if ($urandom_range(0, 3) == 0) cycle();
         end
         cycle();
         cycle();
      end
   endtask

   task automatic test_zero_sweep();
      int st;
      for (int r = 0; r < 16; r++) issue(0, mk_alu(A_ZERO, 4'(r), 4'd0, 4'd0, 1'b1), st);
      for (int a = 0; a < 256; a++) issue(0, mk_store(4'd0, 8'(a)), st);
      issue(0, mk_alu(INC_A, 4'd1, 4'd1, 4'd1, 1'b1), st);
      issue(0, mk_alu(INC_A, 4'd2, 4'd2, 4'd2, 1'b1), st);
      #1;
      rst_n = 1'b0;
      #2;
      check_idle_outputs("mid_reset");
      rst_n = 1'b1;
      clear_model_after_reset();
      for (int i = 0; i < 3; i++) cycle();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 16; r++) issue(k, mk_alu(PASS_A, 4'd0, 4'(r), 4'(r), 1'b0), st);
      for (int a = 0; a < 256; a++) issue(0, mk_load(4'd0, 8'(a)), st);
      cycle();
      cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = '0; D_wr = '0; RF_s = '0; RF_W_en = '0;
      for (int k = 0; k < 2; k++) begin
         D_addr[k] = '0; RF_W_addr[k] = '0; RF_A_addr[k] = '0; RF_B_addr[k] = '0; ALU_sel[k] = '0;
         for (int r = 0; r < 16; r++) m_rf[k][r] = 16'h0;
         for (int a = 0; a < 256; a++) begin
            m_mem[k][a]   = 16'h0;
            m_known[k][a] = 1'b0;
         end
      end
      test_reset();
      test_load();
      test_load_use();
      test_ex_forward();
      test_store_load();
      test_no_forward();
      test_random();
      test_zero_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
